ongoru_guncelleme_sirasi: RTL and testbench
===========================================

# ongoru_guncelleme_sirasi

Predictor update scheduler between the execute-stage resolvers and the branch predictor's update port. It accepts resolved branch/jump results from two requesters (requester 0: branch unit, requester 1: jump unit). It arbitrates between them round-robin and buffers accepted results in a FIFO. It presents one update per handshake to the predictor, and holds the update port idle for a fixed recovery window after every mispredicted update so the predictor's history rewind completes.

## Interface
- BUYRUK_BIT, 32, instruction/address width
- DERINLIK, 4, FIFO entries (power of two, ≥2)
- KURTARMA_CEVRIM, 2, idle cycles after a mispredicted update (≥1)

- clk_g  in  1  clock, rising edge
- rst_g  in  1  reset, asynchronous, active-low
- istekN_gecerli  in  1  requester N (N=0,1) has a result
- istekN_hazir  out  1  requester N's result accepted this cycle
- istekN_buyruk  in  BUYRUK_BIT  resolved instruction
- istekN_adres  in  BUYRUK_BIT  resolved instruction address
- istekN_atladi  in  1  branch taken
- istekN_hedef  in  BUYRUK_BIT  resolved target
- istekN_yanlis  in  1  prediction was wrong
- i_temizle  in  1  synchronous flush
- guncelle_gecerli_g  out  1  update valid to predictor
- i_guncelle_hazir  in  1  predictor accepts update
- o_eski_buyruk, o_eski_buyruk_adresi, o_atlanan_adres  out  BUYRUK_BIT  head entry fields
- o_buyruk_atladi, o_ongoru_yanlis  out  1  head entry flags
- o_guncelleme_sayaci  out  16  completed updates, wraps
- o_yanlis_sayaci  out  16  completed mispredicted updates, saturates at 16'hFFFF

## Operation
- FIFO entry = {buyruk, adres, atladi, hedef, yanlis}. Write pointer, read pointer and count are registered. Count is log2(DERINLIK)+1 bits.
- Accept window: kabul_acik = (durum != DURDUR) && !i_temizle && (count < DERINLIK).
- Arbitration: at most one accept per cycle.
  - If exactly one requester is valid, it wins.
  - If both are valid, the winner is the requester not recorded in son_kazanan.
  - son_kazanan updates only on an accept.
  - istekN_hazir = kabul_acik && winner==N && istekN_gecerli.
- Update port:
  - guncelle_gecerli_g = (durum == AKTAR) && (count != 0) && !i_temizle.
  - Data outputs always show the FIFO head entry. They are don't-care when not valid.
  - Dequeue happens on guncelle_gecerli_g && i_guncelle_hazir.
- Enqueue and dequeue in the same cycle: count is unchanged and both pointers advance modulo DERINLIK.
- FSM states:
  - BOSTA: count==0.
  - AKTAR: entries pending.
  - DURDUR: recovery window.
- FSM transitions:
  - BOSTA→AKTAR when an accept occurs.
  - AKTAR→DURDUR on a dequeue whose entry has yanlis=1. bekle_sayaci loads KURTARMA_CEVRIM−1.
  - AKTAR→BOSTA on a non-mispredict dequeue that empties the FIFO with no simultaneous accept.
  - DURDUR: bekle_sayaci decrements each cycle. At 0 the FSM goes to AKTAR if count≠0, else BOSTA.
- Counters, on each dequeue:
  - o_guncelleme_sayaci increments by 1.
  - o_yanlis_sayaci increments by 1 if yanlis=1 and the counter is not already saturated.
- i_temizle:
  - That cycle: all hazir outputs and guncelle_gecerli_g are forced to 0.
  - At the next edge: pointers and count clear, durum→BOSTA, bekle_sayaci→0.
  - son_kazanan and both statistics counters are preserved.

## Timing
- Reset (rst_g=0, asynchronous) sets:
  - count, pointers and bekle_sayaci to 0.
  - durum=BOSTA and son_kazanan=1, so requester 0 wins the first conflict.
  - Both statistics counters to 0.
- Resulting output values during and after reset: guncelle_gecerli_g=0 and istekN_hazir=0. hazir still follows kabul_acik combinationally, so it can rise in the first cycle after reset deasserts. Reset deassertion mid-operation discards all queued entries.
- Latency: a result accepted at edge N is visible on the update port from edge N onward, i.e. guncelle_gecerli_g in cycle N+1 at the earliest. There is no combinational path from istek* to update outputs.
- Full FIFO: the accept window closes even if a dequeue happens in the same cycle, so there is no pass-through. It reopens the cycle after count<DERINLIK.
- After a mispredicted dequeue at edge M:
  - guncelle_gecerli_g=0 and all hazir=0 for exactly KURTARMA_CEVRIM cycles (M+1 … M+KURTARMA_CEVRIM).
  - The first new update or accept is possible in cycle M+KURTARMA_CEVRIM+1.
- Requesters must hold gecerli and data stable until hazir is sampled high.

## Test plan
- Reset: after rst_g low→high, guncelle_gecerli_g=0 and both counters=0. With istek0_gecerli=1, hazir0=1 in the first cycle. The entry (adres=32'h100, hedef=32'h140) appears on the update port in the next cycle.
- Round-robin: both requesters valid continuously, predictor always ready. The grant sequence is 0,1,0,1. o_guncelleme_sayaci reaches 4 four cycles after the first dequeue.
- Full/backpressure: i_guncelle_hazir=0 and 6 requests from requester 0. Exactly 4 are accepted and hazir0 stays 0 while full. Releasing hazir drains entries in FIFO order (adres 0x0,0x4,0x8,0xC).
- Recovery: a queue of [yanlis=1, yanlis=0] with KURTARMA_CEVRIM=2. The first dequeue is followed by 2 cycles with guncelle_gecerli_g=0. The second entry is presented in the 3rd cycle and o_yanlis_sayaci=1.
- Flush: 3 entries queued, i_temizle pulsed one cycle. In that cycle gecerli and hazir are both 0. Next cycle count=0, durum=BOSTA, and counters are unchanged.
- Saturation: preload or drive 65536 mispredicted updates. o_yanlis_sayaci holds 16'hFFFF while o_guncelleme_sayaci wraps to 0.

Source files
------------

// File: rtl/ongoru_guncelleme_sirasi_if.sv
// Bus between the execute-stage resolvers, the update scheduler and the
// branch predictor's update port.
interface ongoru_guncelleme_sirasi_if #(
  parameter int BUYRUK_BIT = 32
);
  logic                  istek0_gecerli;
  logic                  istek0_hazir;
  logic [BUYRUK_BIT-1:0] istek0_buyruk;
  logic [BUYRUK_BIT-1:0] istek0_adres;
  logic                  istek0_atladi;
  logic [BUYRUK_BIT-1:0] istek0_hedef;
  logic                  istek0_yanlis;

  logic                  istek1_gecerli;
  logic                  istek1_hazir;
  logic [BUYRUK_BIT-1:0] istek1_buyruk;
  logic [BUYRUK_BIT-1:0] istek1_adres;
  logic                  istek1_atladi;
  logic [BUYRUK_BIT-1:0] istek1_hedef;
  logic                  istek1_yanlis;

  logic                  guncelle_gecerli_g;
  logic                  i_guncelle_hazir;
  logic [BUYRUK_BIT-1:0] o_eski_buyruk;
  logic [BUYRUK_BIT-1:0] o_eski_buyruk_adresi;
  logic [BUYRUK_BIT-1:0] o_atlanan_adres;
  logic                  o_buyruk_atladi;
  logic                  o_ongoru_yanlis;
  logic [15:0]           o_guncelleme_sayaci;
  logic [15:0]           o_yanlis_sayaci;

  // Requester/predictor side
  modport master (
    output istek0_gecerli, istek0_buyruk, istek0_adres, istek0_atladi,
           istek0_hedef, istek0_yanlis,
    input  istek0_hazir,
    output istek1_gecerli, istek1_buyruk, istek1_adres, istek1_atladi,
           istek1_hedef, istek1_yanlis,
    input  istek1_hazir,
    input  guncelle_gecerli_g, o_eski_buyruk, o_eski_buyruk_adresi,
           o_atlanan_adres, o_buyruk_atladi, o_ongoru_yanlis,
           o_guncelleme_sayaci, o_yanlis_sayaci,
    output i_guncelle_hazir
  );

  // Scheduler side
  modport slave (
    input  istek0_gecerli, istek0_buyruk, istek0_adres, istek0_atladi,
           istek0_hedef, istek0_yanlis,
    output istek0_hazir,
    input  istek1_gecerli, istek1_buyruk, istek1_adres, istek1_atladi,
           istek1_hedef, istek1_yanlis,
    output istek1_hazir,
    output guncelle_gecerli_g, o_eski_buyruk, o_eski_buyruk_adresi,
           o_atlanan_adres, o_buyruk_atladi, o_ongoru_yanlis,
           o_guncelleme_sayaci, o_yanlis_sayaci,
    input  i_guncelle_hazir
  );
endinterface

// File: rtl/ongoru_guncelleme_sirasi.sv
// Predictor update scheduler: round-robin intake from two resolvers, FIFO
// buffering, and a fixed idle window after each mispredicted update.
module ongoru_guncelleme_sirasi #(
  parameter int BUYRUK_BIT      = 32,
  parameter int DERINLIK        = 4,
  parameter int KURTARMA_CEVRIM = 2
) (
  input  logic clk_g,
  input  logic rst_g,
  input  logic i_temizle,
  ongoru_guncelleme_sirasi_if.slave bus
);

  localparam int PW = $clog2(DERINLIK);
  localparam int CW = PW + 1;
  localparam int BW = (KURTARMA_CEVRIM > 1) ? $clog2(KURTARMA_CEVRIM) : 1;

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    AKTAR  = 2'd1,
    DURDUR = 2'd2
  } durum_t;

  typedef struct packed {
    logic [BUYRUK_BIT-1:0] buyruk;
    logic [BUYRUK_BIT-1:0] adres;
    logic                  atladi;
    logic [BUYRUK_BIT-1:0] hedef;
    logic                  yanlis;
  } giris_t;

  durum_t        durum_q, durum_d;
  logic [BW-1:0] bekle_q, bekle_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          son_kazanan_q, son_kazanan_d;
  logic [15:0]   guncelleme_sayaci_q, guncelleme_sayaci_d;
  logic [15:0]   yanlis_sayaci_q, yanlis_sayaci_d;

  giris_t mem_q [DERINLIK];
  giris_t yeni;
  giris_t bas;

  logic kabul_acik;
  logic kazanan;
  logic hazir0, hazir1;
  logic kabul;
  logic gecerli;
  logic deq;

  // Intake: one accept per cycle, the side not served last wins a conflict
  always_comb begin
    kabul_acik = (durum_q != DURDUR) && !i_temizle && (count_q < CW'(DERINLIK));
    if (bus.istek0_gecerli && bus.istek1_gecerli) kazanan = ~son_kazanan_q;
    else                                          kazanan = bus.istek1_gecerli;
    hazir0 = kabul_acik && !kazanan && bus.istek0_gecerli;
    hazir1 = kabul_acik &&  kazanan && bus.istek1_gecerli;
    kabul  = hazir0 || hazir1;
    if (kazanan) yeni = '{bus.istek1_buyruk, bus.istek1_adres, bus.istek1_atladi,
                          bus.istek1_hedef, bus.istek1_yanlis};
    else         yeni = '{bus.istek0_buyruk, bus.istek0_adres, bus.istek0_atladi,
                          bus.istek0_hedef, bus.istek0_yanlis};
  end

  assign bas     = mem_q[rd_ptr_q];
  assign gecerli = (durum_q == AKTAR) && (count_q != '0) && !i_temizle;
  assign deq     = gecerli && bus.i_guncelle_hazir;

  always_comb begin
    wr_ptr_d            = wr_ptr_q;
    rd_ptr_d            = rd_ptr_q;
    count_d             = count_q;
    durum_d             = durum_q;
    bekle_d             = bekle_q;
    son_kazanan_d       = son_kazanan_q;
    guncelleme_sayaci_d = guncelleme_sayaci_q;
    yanlis_sayaci_d     = yanlis_sayaci_q;

    if (kabul) begin
      wr_ptr_d      = wr_ptr_q + PW'(1);
      son_kazanan_d = kazanan;
    end
    if (deq) begin
      rd_ptr_d            = rd_ptr_q + PW'(1);
      guncelleme_sayaci_d = guncelleme_sayaci_q + 16'd1;
      if (bas.yanlis && (yanlis_sayaci_q != 16'hFFFF))
        yanlis_sayaci_d = yanlis_sayaci_q + 16'd1;
    end
    count_d = count_q + CW'(kabul) - CW'(deq);

    case (durum_q)
      BOSTA: if (kabul) durum_d = AKTAR;
      AKTAR: begin
        if (deq && bas.yanlis) begin
          durum_d = DURDUR;
          bekle_d = BW'(KURTARMA_CEVRIM - 1);
        end else if (deq && (count_q == CW'(1)) && !kabul) begin
          durum_d = BOSTA;
        end
      end
      DURDUR: begin
        if (bekle_q == '0) durum_d = (count_q != '0) ? AKTAR : BOSTA;
        else               bekle_d = bekle_q - BW'(1);
      end
      default: durum_d = BOSTA;
    endcase

    // Flush drops the queue and recovery state but keeps fairness and statistics
    if (i_temizle) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      durum_d  = BOSTA;
      bekle_d  = '0;
    end
  end

  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) begin
      durum_q             <= BOSTA;
      bekle_q             <= '0;
      wr_ptr_q            <= '0;
      rd_ptr_q            <= '0;
      count_q             <= '0;
      son_kazanan_q       <= 1'b1;
      guncelleme_sayaci_q <= '0;
      yanlis_sayaci_q     <= '0;
    end else begin
      durum_q             <= durum_d;
      bekle_q             <= bekle_d;
      wr_ptr_q            <= wr_ptr_d;
      rd_ptr_q            <= rd_ptr_d;
      count_q             <= count_d;
      son_kazanan_q       <= son_kazanan_d;
      guncelleme_sayaci_q <= guncelleme_sayaci_d;
      yanlis_sayaci_q     <= yanlis_sayaci_d;
    end
  end

  // Entry storage carries no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk_g) begin
    if (kabul) mem_q[wr_ptr_q] <= yeni;
  end

  assign bus.istek0_hazir         = hazir0;
  assign bus.istek1_hazir         = hazir1;
  assign bus.guncelle_gecerli_g   = gecerli;
  assign bus.o_eski_buyruk        = bas.buyruk;
  assign bus.o_eski_buyruk_adresi = bas.adres;
  assign bus.o_atlanan_adres      = bas.hedef;
  assign bus.o_buyruk_atladi      = bas.atladi;
  assign bus.o_ongoru_yanlis      = bas.yanlis;
  assign bus.o_guncelleme_sayaci  = guncelleme_sayaci_q;
  assign bus.o_yanlis_sayaci      = yanlis_sayaci_q;

endmodule

// File: tb/tb_ongoru_guncelleme_sirasi.sv
// Directed bench for the predictor update scheduler: reset, round-robin,
// backpressure, recovery window, flush and counter saturation.
module tb_ongoru_guncelleme_sirasi;

  logic clk_g = 1'b0;
  logic rst_g;
  logic i_temizle;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_g = ~clk_g;

  ongoru_guncelleme_sirasi_if #(.BUYRUK_BIT(32)) bus ();

  ongoru_guncelleme_sirasi #(
    .BUYRUK_BIT(32), .DERINLIK(4), .KURTARMA_CEVRIM(2)
  ) dut (
    .clk_g(clk_g), .rst_g(rst_g), .i_temizle(i_temizle), .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_g);
    #1;
  endtask

  task automatic req0(input logic g, input logic [31:0] adr, input logic y);
    bus.istek0_gecerli = g;
    bus.istek0_adres   = adr;
    bus.istek0_hedef   = adr + 32'h40;
    bus.istek0_buyruk  = {adr[23:0], 8'h63};
    bus.istek0_atladi  = 1'b1;
    bus.istek0_yanlis  = y;
  endtask

  task automatic req1(input logic g, input logic [31:0] adr, input logic y);
    bus.istek1_gecerli = g;
    bus.istek1_adres   = adr;
    bus.istek1_hedef   = adr + 32'h80;
    bus.istek1_buyruk  = {adr[23:0], 8'h6F};
    bus.istek1_atladi  = 1'b0;
    bus.istek1_yanlis  = y;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_g = 1'b0;
    i_temizle = 1'b0;
    bus.i_guncelle_hazir = 1'b0;
    req0(1'b0, 32'h0, 1'b0);
    req1(1'b0, 32'h0, 1'b0);

    // Reset
    repeat (2) tick();
    #1;
    chk("rst_gecerli", 32'(bus.guncelle_gecerli_g), 32'd0);
    chk("rst_hazir0", 32'(bus.istek0_hazir), 32'd0);
    chk("rst_hazir1", 32'(bus.istek1_hazir), 32'd0);
    chk("rst_gsay", 32'(bus.o_guncelleme_sayaci), 32'd0);
    chk("rst_ysay", 32'(bus.o_yanlis_sayaci), 32'd0);
    rst_g = 1'b1;
    req0(1'b1, 32'h100, 1'b0);
    #1;
    chk("first_hazir0", 32'(bus.istek0_hazir), 32'd1);
    chk("first_nogecerli", 32'(bus.guncelle_gecerli_g), 32'd0);
    tick();
    req0(1'b0, 32'h0, 1'b0);
    #1;
    chk("first_gecerli", 32'(bus.guncelle_gecerli_g), 32'd1);
    chk("first_adres", bus.o_eski_buyruk_adresi, 32'h100);
    chk("first_hedef", bus.o_atlanan_adres, 32'h140);
    chk("first_buyruk", bus.o_eski_buyruk, 32'h00010063);
    chk("first_atladi", 32'(bus.o_buyruk_atladi), 32'd1);
    chk("first_yanlis", 32'(bus.o_ongoru_yanlis), 32'd0);
    bus.i_guncelle_hazir = 1'b1;
    tick();
    #1;
    chk("first_gsay", 32'(bus.o_guncelleme_sayaci), 32'd1);
    chk("first_empty", 32'(bus.guncelle_gecerli_g), 32'd0);

    // Round-robin after a fresh reset (requester 0 wins first conflict)
    rst_g = 1'b0;
    #1;
    rst_g = 1'b1;
    chk("rr_rst_gsay", 32'(bus.o_guncelleme_sayaci), 32'd0);
    req0(1'b1, 32'h200, 1'b0);
    req1(1'b1, 32'h300, 1'b0);
    #1;
    chk("rr1_h0", 32'(bus.istek0_hazir), 32'd1);
    chk("rr1_h1", 32'(bus.istek1_hazir), 32'd0);
    tick();
    req0(1'b1, 32'h204, 1'b0);
    #1;
    chk("rr2_h0", 32'(bus.istek0_hazir), 32'd0);
    chk("rr2_h1", 32'(bus.istek1_hazir), 32'd1);
    chk("rr2_head", bus.o_eski_buyruk_adresi, 32'h200);
    tick();
    req1(1'b1, 32'h304, 1'b0);
    #1;
    chk("rr3_h0", 32'(bus.istek0_hazir), 32'd1);
    chk("rr3_h1", 32'(bus.istek1_hazir), 32'd0);
    chk("rr3_head", bus.o_eski_buyruk_adresi, 32'h300);
    chk("rr3_hedef", bus.o_atlanan_adres, 32'h380);
    tick();
    req0(1'b1, 32'h208, 1'b0);
    #1;
    chk("rr4_h0", 32'(bus.istek0_hazir), 32'd0);
    chk("rr4_h1", 32'(bus.istek1_hazir), 32'd1);
    chk("rr4_head", bus.o_eski_buyruk_adresi, 32'h204);
    tick();
    req0(1'b0, 32'h0, 1'b0);
    req1(1'b0, 32'h0, 1'b0);
    #1;
    chk("rr5_head", bus.o_eski_buyruk_adresi, 32'h304);
    chk("rr5_gecerli", 32'(bus.guncelle_gecerli_g), 32'd1);
    tick();
    #1;
    chk("rr_gsay", 32'(bus.o_guncelleme_sayaci), 32'd4);
    chk("rr_empty", 32'(bus.guncelle_gecerli_g), 32'd0);
    bus.i_guncelle_hazir = 1'b0;

    // Full FIFO and backpressure
    req0(1'b1, 32'h0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("full_hazir0", 32'(bus.istek0_hazir), (k < 4) ? 32'd1 : 32'd0);
      tick();
      if (k < 4) req0(1'b1, 32'(4 * (k + 1)), 1'b0);
    end
    #1;
    chk("full_gecerli", 32'(bus.guncelle_gecerli_g), 32'd1);
    bus.i_guncelle_hazir = 1'b1;
    #1;
    chk("full_nopass", 32'(bus.istek0_hazir), 32'd0);
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("drain_gecerli", 32'(bus.guncelle_gecerli_g), 32'd1);
      chk("drain_adres", bus.o_eski_buyruk_adresi, 32'(4 * j));
      tick();
      req0(1'b0, 32'h0, 1'b0);
    end
    #1;
    chk("drain_empty", 32'(bus.guncelle_gecerli_g), 32'd0);
    chk("drain_gsay", 32'(bus.o_guncelleme_sayaci), 32'd8);
    bus.i_guncelle_hazir = 1'b0;

    // Recovery window after a mispredicted update
    req1(1'b1, 32'h40, 1'b1);
    #1;
    chk("rec_acc1", 32'(bus.istek1_hazir), 32'd1);
    tick();
    req1(1'b1, 32'h44, 1'b0);
    tick();
    req1(1'b0, 32'h0, 1'b0);
    bus.i_guncelle_hazir = 1'b1;
    #1;
    chk("rec_head", bus.o_eski_buyruk_adresi, 32'h40);
    chk("rec_flag", 32'(bus.o_ongoru_yanlis), 32'd1);
    chk("rec_gecerli", 32'(bus.guncelle_gecerli_g), 32'd1);
    tick();
    req0(1'b1, 32'h50, 1'b0);
    #1;
    chk("rec_idle1_g", 32'(bus.guncelle_gecerli_g), 32'd0);
    chk("rec_idle1_h", 32'(bus.istek0_hazir), 32'd0);
    chk("rec_ysay", 32'(bus.o_yanlis_sayaci), 32'd1);
    tick();
    #1;
    chk("rec_idle2_g", 32'(bus.guncelle_gecerli_g), 32'd0);
    chk("rec_idle2_h", 32'(bus.istek0_hazir), 32'd0);
    tick();
    #1;
    chk("rec_resume_g", 32'(bus.guncelle_gecerli_g), 32'd1);
    chk("rec_resume_adr", bus.o_eski_buyruk_adresi, 32'h44);
    chk("rec_resume_h", 32'(bus.istek0_hazir), 32'd1);
    tick();
    req0(1'b0, 32'h0, 1'b0);
    #1;
    chk("rec_next_adr", bus.o_eski_buyruk_adresi, 32'h50);
    chk("rec_next_g", 32'(bus.guncelle_gecerli_g), 32'd1);
    tick();
    #1;
    chk("rec_empty", 32'(bus.guncelle_gecerli_g), 32'd0);
    chk("rec_gsay", 32'(bus.o_guncelleme_sayaci), 32'd11);
    bus.i_guncelle_hazir = 1'b0;

    // Flush with three entries queued
    for (int k = 0; k < 3; k++) begin
      req0(1'b1, 32'(32'h60 + 4 * k), 1'b0);
      tick();
    end
    req0(1'b1, 32'h6C, 1'b0);
    bus.i_guncelle_hazir = 1'b1;
    i_temizle = 1'b1;
    #1;
    chk("fl_gecerli", 32'(bus.guncelle_gecerli_g), 32'd0);
    chk("fl_hazir0", 32'(bus.istek0_hazir), 32'd0);
    tick();
    i_temizle = 1'b0;
    req0(1'b0, 32'h0, 1'b0);
    #1;
    chk("fl_count", 32'(dut.count_q), 32'd0);
    chk("fl_durum", 32'(dut.durum_q), 32'd0);
    chk("fl_gecerli2", 32'(bus.guncelle_gecerli_g), 32'd0);
    chk("fl_gsay", 32'(bus.o_guncelleme_sayaci), 32'd11);
    chk("fl_ysay", 32'(bus.o_yanlis_sayaci), 32'd1);
    bus.i_guncelle_hazir = 1'b0;

    // Saturation / wrap from a preloaded count
    req0(1'b1, 32'h70, 1'b1);
    tick();
    req0(1'b1, 32'h74, 1'b1);
    tick();
    req0(1'b0, 32'h0, 1'b0);
    force dut.yanlis_sayaci_q = 16'hFFFE;
    force dut.guncelleme_sayaci_q = 16'hFFFE;
    #1;
    release dut.yanlis_sayaci_q;
    release dut.guncelleme_sayaci_q;
    #1;
    chk("sat_pre", 32'(bus.o_yanlis_sayaci), 32'h0000FFFE);
    bus.i_guncelle_hazir = 1'b1;
    tick();
    #1;
    chk("sat_y1", 32'(bus.o_yanlis_sayaci), 32'h0000FFFF);
    chk("sat_g1", 32'(bus.o_guncelleme_sayaci), 32'h0000FFFF);
    tick();
    tick();
    #1;
    chk("sat_resume", 32'(bus.guncelle_gecerli_g), 32'd1);
    tick();
    #1;
    chk("sat_y2", 32'(bus.o_yanlis_sayaci), 32'h0000FFFF);
    chk("sat_g2", 32'(bus.o_guncelleme_sayaci), 32'd0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
